// File: rtl/watch_pkg.sv
// Shared stopwatch definitions: recall FSM states, bus widths and RAM timing
// common to the lap-record read and write controllers.
package watch_pkg;

  localparam int unsigned WATCH_ADDR_W   = 4;
  localparam int unsigned WATCH_DATA_W   = 24;
  localparam int unsigned WATCH_READ_LAT = 2;
  localparam int unsigned WATCH_DWELL_MS = 1000;

  localparam logic [WATCH_DATA_W-1:0] WATCH_EMPTY_CODE = 24'hAAAAAA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_EMPTY = 3'd4
  } rr_state_t;

endpackage

// File: rtl/record_reader_if.sv
// Key, RAM-read and display signals between the record reader and its
// surroundings; master is the reader, slave the keys/RAM/display side.
interface record_reader_if
  import watch_pkg::*;
#(
  parameter int unsigned ADDR_W = WATCH_ADDR_W,
  parameter int unsigned DATA_W = WATCH_DATA_W
) ();

  logic              tick_1khz;
  logic              key_recall;
  logic              key_next;
  logic              key_prev;
  logic              key_exit;
  logic [ADDR_W:0]   rec_count;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              active;
  logic [ADDR_W-1:0] rec_index;
  logic              auto_on;

  modport master (
    input  tick_1khz, key_recall, key_next, key_prev, key_exit, rec_count, ram_q,
    output ram_addr, disp_data, disp_valid, active, rec_index, auto_on
  );

  modport slave (
    output tick_1khz, key_recall, key_next, key_prev, key_exit, rec_count, ram_q,
    input  ram_addr, disp_data, disp_valid, active, rec_index, auto_on
  );

endinterface

// File: rtl/record_dwell_timer.sv
// Auto-scroll dwell timer: counts tick_1khz pulses while enabled and flags the
// tick that completes DWELL_MS of dwell.
module record_dwell_timer
  import watch_pkg::*;
#(
  parameter int unsigned DWELL_MS = WATCH_DWELL_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_tick,
  input  logic i_clr,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit      = (r_cnt == CNT_W'(DWELL_MS - 1));
  assign o_expire_c = i_en & i_tick & w_hit & ~i_clr;

  // Expiry restarts the dwell so the next record gets a full period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_expire_c) begin
      r_cnt <= '0;
    end else if (i_en && i_tick) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/record_reader.sv
// Lap-record recall controller: fetches records from the lap RAM one at a time,
// presents them for display and steps through them by key or auto-scroll.
module record_reader
  import watch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = WATCH_ADDR_W,
  parameter int unsigned       DATA_W     = WATCH_DATA_W,
  parameter int unsigned       READ_LAT   = WATCH_READ_LAT,
  parameter int unsigned       DWELL_MS   = WATCH_DWELL_MS,
  parameter logic [DATA_W-1:0] EMPTY_CODE = DATA_W'(WATCH_EMPTY_CODE)
) (
  input logic             clk,
  input logic             rst,
  record_reader_if.master bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  rr_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_total, w_total_nxt;
  logic [ADDR_W-1:0] r_index, w_index_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [DATA_W-1:0] r_disp_data, w_disp_data_nxt;
  logic              r_disp_valid, w_disp_valid_nxt;
  logic              r_active, w_active_nxt;
  logic [ADDR_W-1:0] r_rec_index, w_rec_index_nxt;
  logic              r_auto_on, w_auto_on_nxt;

  logic              w_exit, w_fwd, w_back, w_step, w_expire_c, w_dwell_clr, w_dwell_en;
  logic [ADDR_W-1:0] w_last, w_index_step;

  assign w_exit = (r_state != ST_IDLE) & bus.key_exit;
  assign w_fwd  = (bus.key_next & ~bus.key_prev) | w_expire_c;
  assign w_back = bus.key_prev & ~bus.key_next;
  assign w_step = w_fwd | w_back;
  assign w_last = ADDR_W'(r_total - CNT_W'(1));

  // Wrap at both ends of the session's frozen record count
  always_comb begin
    w_index_step = r_index;
    if (w_fwd) begin
      w_index_step = (r_index == w_last) ? '0 : r_index + ADDR_W'(1);
    end else if (w_back) begin
      w_index_step = (r_index == '0) ? w_last : r_index - ADDR_W'(1);
    end
  end

  assign w_dwell_en  = (r_state == ST_SHOW) & r_auto_on;
  assign w_dwell_clr = (r_state != ST_SHOW) | bus.key_recall | bus.key_next |
                       bus.key_prev | bus.key_exit;

  record_dwell_timer #(.DWELL_MS(DWELL_MS)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_dwell_en),
    .i_tick     (bus.tick_1khz),
    .i_clr      (w_dwell_clr),
    .o_expire_c (w_expire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_total      <= '0;
      r_index      <= '0;
      r_wait       <= '0;
      r_ram_addr   <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_active     <= 1'b0;
      r_rec_index  <= '0;
      r_auto_on    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_total      <= w_total_nxt;
      r_index      <= w_index_nxt;
      r_wait       <= w_wait_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_active     <= w_active_nxt;
      r_rec_index  <= w_rec_index_nxt;
      r_auto_on    <= w_auto_on_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_exit) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.key_recall) w_state_nxt = (bus.rec_count == '0) ? ST_EMPTY : ST_FETCH;
        end
        ST_FETCH: w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (r_wait == '0) w_state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          if (w_step) w_state_nxt = ST_FETCH;
        end
        ST_EMPTY: w_state_nxt = ST_EMPTY;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // The RAM address moves as soon as a step is decided so ram_q is settled
  // by the time the wait count expires
  always_comb begin
    w_total_nxt      = r_total;
    w_index_nxt      = r_index;
    w_wait_nxt       = r_wait;
    w_ram_addr_nxt   = r_ram_addr;
    w_disp_data_nxt  = r_disp_data;
    w_disp_valid_nxt = r_disp_valid;
    w_active_nxt     = r_active;
    w_rec_index_nxt  = r_rec_index;
    w_auto_on_nxt    = r_auto_on;
    if (w_exit) begin
      w_active_nxt     = 1'b0;
      w_disp_valid_nxt = 1'b0;
      w_auto_on_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.key_recall) begin
            w_active_nxt = 1'b1;
            if (bus.rec_count == '0) begin
              w_disp_data_nxt  = EMPTY_CODE;
              w_disp_valid_nxt = 1'b1;
            end else begin
              w_total_nxt    = bus.rec_count;
              w_index_nxt    = '0;
              w_ram_addr_nxt = '0;
            end
          end
        end
        ST_FETCH: begin
          w_ram_addr_nxt   = r_index;
          w_disp_valid_nxt = 1'b0;
          w_wait_nxt       = WAIT_W'(READ_LAT - 1);
        end
        ST_WAIT: begin
          if (r_wait == '0) begin
            w_disp_data_nxt  = bus.ram_q;
            w_disp_valid_nxt = 1'b1;
            w_rec_index_nxt  = r_index;
          end else begin
            w_wait_nxt = r_wait - WAIT_W'(1);
          end
        end
        ST_SHOW: begin
          if (bus.key_recall) w_auto_on_nxt = ~r_auto_on;
          if (w_step) begin
            w_index_nxt    = w_index_step;
            w_ram_addr_nxt = w_index_step;
          end
        end
        ST_EMPTY: w_disp_valid_nxt = 1'b1;
        default:  w_active_nxt     = 1'b0;
      endcase
    end
  end

  assign bus.ram_addr   = r_ram_addr;
  assign bus.disp_data  = r_disp_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.active     = r_active;
  assign bus.rec_index  = r_rec_index;
  assign bus.auto_on    = r_auto_on;

endmodule

// File: tb/tb_record_reader.sv
// Directed self-checking bench for record_reader with a registered-address,
// registered-output RAM model (two-clock read latency).
module tb_record_reader;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [23:0] mem [16];
  logic [3:0]  r_addr_q;

  record_reader_if #(.ADDR_W(4), .DATA_W(24)) bus ();

  record_reader #(.DWELL_MS(3)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    r_addr_q  <= bus.ram_addr;
    bus.ram_q <= mem[r_addr_q];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one-cycle key pulses; returns at the negedge after the sampling edge
  task automatic keys(input logic rc, input logic nx, input logic pv, input logic ex);
    @(negedge clk);
    bus.key_recall = rc;
    bus.key_next   = nx;
    bus.key_prev   = pv;
    bus.key_exit   = ex;
    @(negedge clk);
    bus.key_recall = 1'b0;
    bus.key_next   = 1'b0;
    bus.key_prev   = 1'b0;
    bus.key_exit   = 1'b0;
  endtask

  task automatic send_tick();
    cycles(9);
    bus.tick_1khz = 1'b1;
    @(negedge clk);
    bus.tick_1khz = 1'b0;
  endtask

  task automatic expect_rec(input string tag, input logic [3:0] idx, input logic [23:0] data);
    check({tag, "_valid"}, 32'(bus.disp_valid), 32'd1);
    check({tag, "_index"}, 32'(bus.rec_index), 32'(idx));
    check({tag, "_data"},  32'(bus.disp_data), 32'(data));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 24'(i) << 20;
    mem[0] = 24'h000123;
    mem[1] = 24'h004560;
    mem[2] = 24'h012000;
    rst_n          = 1'b0;
    bus.tick_1khz  = 1'b0;
    bus.key_recall = 1'b0;
    bus.key_next   = 1'b0;
    bus.key_prev   = 1'b0;
    bus.key_exit   = 1'b0;
    bus.rec_count  = 5'd3;
    cycles(3);
    check("rst_addr",   32'(bus.ram_addr),   32'd0);
    check("rst_data",   32'(bus.disp_data),  32'd0);
    check("rst_valid",  32'(bus.disp_valid), 32'd0);
    check("rst_active", 32'(bus.active),     32'd0);
    check("rst_index",  32'(bus.rec_index),  32'd0);
    check("rst_auto",   32'(bus.auto_on),    32'd0);
    rst_n = 1'b1;
    cycles(2);

    // First recall: valid exactly four clocks after the recall edge
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    check("entry_active", 32'(bus.active), 32'd1);
    cycles(2);
    check("entry_not_yet", 32'(bus.disp_valid), 32'd0);
    cycles(1);
    expect_rec("first", 4'd0, 24'h000123);

    keys(1'b0, 1'b1, 1'b0, 1'b0); cycles(3); expect_rec("next1", 4'd1, 24'h004560);
    keys(1'b0, 1'b1, 1'b0, 1'b0); cycles(3); expect_rec("next2", 4'd2, 24'h012000);
    keys(1'b0, 1'b1, 1'b0, 1'b0); cycles(3); expect_rec("wrap_next", 4'd0, 24'h000123);
    keys(1'b0, 1'b0, 1'b1, 1'b0); cycles(3); expect_rec("wrap_prev", 4'd2, 24'h012000);
    keys(1'b0, 1'b1, 1'b1, 1'b0);
    check("both_valid_now", 32'(bus.disp_valid), 32'd1);
    cycles(3); expect_rec("both_keys", 4'd2, 24'h012000);

    // Auto-scroll with a dwell of three ticks
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_on", 32'(bus.auto_on), 32'd1);
    send_tick(); send_tick(); cycles(3);
    check("auto_hold", 32'(bus.rec_index), 32'd2);
    send_tick(); cycles(3); expect_rec("auto_wrap", 4'd0, 24'h000123);
    send_tick(); send_tick(); send_tick(); cycles(3);
    expect_rec("auto_adv", 4'd1, 24'h004560);
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    check("auto_off", 32'(bus.auto_on), 32'd0);
    for (int i = 0; i < 4; i++) send_tick();
    cycles(3); expect_rec("auto_frozen", 4'd1, 24'h004560);

    keys(1'b0, 1'b0, 1'b0, 1'b1);
    check("exit_active", 32'(bus.active),     32'd0);
    check("exit_valid",  32'(bus.disp_valid), 32'd0);
    check("exit_index",  32'(bus.rec_index),  32'd1);
    check("exit_data",   32'(bus.disp_data),  32'h004560);

    // No records stored
    bus.rec_count = 5'd0;
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    check("empty_active", 32'(bus.active),     32'd1);
    check("empty_valid",  32'(bus.disp_valid), 32'd1);
    check("empty_data",   32'(bus.disp_data),  32'hAAAAAA);
    keys(1'b0, 1'b1, 1'b0, 1'b0); cycles(3);
    check("empty_next_data",  32'(bus.disp_data),  32'hAAAAAA);
    check("empty_next_valid", 32'(bus.disp_valid), 32'd1);
    keys(1'b0, 1'b0, 1'b0, 1'b1);
    check("empty_exit", 32'(bus.active), 32'd0);

    // Exit beats next during WAIT; the pending read is never captured
    bus.rec_count = 5'd3;
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b1, 1'b0, 1'b1);
    check("wexit_active", 32'(bus.active),     32'd0);
    check("wexit_valid",  32'(bus.disp_valid), 32'd0);
    cycles(4);
    check("wexit_valid_later", 32'(bus.disp_valid), 32'd0);
    check("wexit_data_held",   32'(bus.disp_data),  32'hAAAAAA);
    check("wexit_addr",        32'(bus.ram_addr),   32'd0);

    // Asynchronous reset in the middle of WAIT
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_active", 32'(bus.active),    32'd0);
    check("arst_data",   32'(bus.disp_data), 32'd0);
    check("arst_index",  32'(bus.rec_index), 32'd0);
    check("arst_auto",   32'(bus.auto_on),   32'd0);
    cycles(2);
    check("arst_valid",  32'(bus.disp_valid), 32'd0);
    rst_n = 1'b1;
    cycles(1);
    keys(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(3); expect_rec("post_rst", 4'd0, 24'h000123);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/record_reader.md
Name: record_reader

Overview:
- Read-side controller for the stopwatch lap-record RAM (16 x 24-bit, 1-port). The write side stores laps.
- On a recall request, the block fetches stored records one at a time, presents each as a 6-digit BCD display word, and steps forward or back on key pulses.
- Optional auto-scroll advances one record every DWELL_MS milliseconds.
- Sits between the key conditioning logic and the RAM/display mux. While active it owns the RAM address (write enable held low by the top level).

Parameters:
- ADDR_W, 4: RAM address width (depth 2**ADDR_W).
- DATA_W, 24: record width (6 BCD digits).
- READ_LAT, 2: clocks from address change to valid ram_q (registered address + registered output).
- DWELL_MS, 1000: auto-scroll dwell, counted in tick_1khz pulses (16-bit counter).
- EMPTY_CODE, 24'hAAAAAA: display word shown when no records exist.

Ports:
- clk, in, 1: system clock (50 MHz).
- rst, in, 1: asynchronous, active-low reset (0 = reset).
- tick_1khz, in, 1: single-cycle 1 kHz enable, synchronous to clk.
- key_recall, in, 1: debounced single-cycle pulse; enter recall, or toggle auto-scroll while showing.
- key_next, in, 1: debounced pulse; next record.
- key_prev, in, 1: debounced pulse; previous record.
- key_exit, in, 1: debounced pulse; leave recall.
- rec_count, in, ADDR_W+1: number of valid records, 0..16.
- ram_q, in, DATA_W: RAM read data.
- ram_addr, out, ADDR_W: RAM read address.
- disp_data, out, DATA_W: record for display.
- disp_valid, out, 1: disp_data holds a fetched record or EMPTY_CODE.
- active, out, 1: recall mode; the top-level mux selects disp_data.
- rec_index, out, ADDR_W: index of the displayed record.
- auto_on, out, 1: auto-scroll enabled.

Behaviour:
- Reset values: state IDLE; ram_addr=0, disp_data=0, disp_valid=0, active=0, rec_index=0, auto_on=0; internal total=0, wait/dwell counters 0.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, SHOW, EMPTY.
- IDLE:
  - key_recall with rec_count==0 -> EMPTY.
  - key_recall with rec_count>0 -> latch total=rec_count, index=0, ram_addr=0 -> FETCH.
  - active=1 from the next cycle.
  - rec_count is frozen in total for the whole session; later changes are ignored until re-entry.
- FETCH: one cycle; ram_addr=index; disp_valid=0; load wait counter = READ_LAT-1 -> WAIT.
- WAIT: decrement the counter. At 0, disp_data<=ram_q, disp_valid<=1, rec_index<=index -> SHOW.
  - First valid display is exactly READ_LAT+2 clocks after the recall pulse.
- SHOW:
  - key_next: index = (index==total-1) ? 0 : index+1 -> FETCH.
  - key_prev: index = (index==0) ? total-1 : index-1 -> FETCH.
  - key_next and key_prev in the same cycle: both ignored.
  - key_recall: toggle auto_on and clear the dwell counter.
  - auto_on: count tick_1khz. When the count reaches DWELL_MS, clear it and act as key_next.
  - Manual next/prev also clears the dwell counter.
- EMPTY: disp_data=EMPTY_CODE, disp_valid=1, active=1. Next, prev and recall are ignored.
- key_exit in any non-IDLE state (FETCH/WAIT included) -> IDLE next cycle.
  - active=0, disp_valid=0, auto_on=0.
  - disp_data and rec_index hold their last value.
  - Exit has priority over every other key in the same cycle.
- Keys other than exit arriving in FETCH/WAIT are dropped (not queued).
- total==1: next and prev both refetch index 0.
- Async reset asserted mid-fetch aborts immediately to the reset values; there is no RAM side effect because the block never writes.

Decomposition:
- Shared package (watch_pkg): state enum, ADDR_W/DATA_W defaults, EMPTY_CODE, and the RAM read-latency constant shared with the write-side controller.
- Sub-module: record_dwell_timer, holding the tick_1khz counter, clear input and expiry pulse output. The FSM stays in record_reader.

Test Plan:
- Preload RAM[0..2]=24'h000123, 24'h004560, 24'h012000; rec_count=3; pulse key_recall -> disp_valid rises 4 clocks later with disp_data=24'h000123 and rec_index=0.
- From index 2, pulse key_next -> rec_index=0, disp_data=24'h000123. From index 0, pulse key_prev -> rec_index=2, disp_data=24'h012000.
- rec_count=0, pulse key_recall -> disp_data=24'hAAAAAA, active=1. Then pulse key_next -> no change. Then pulse key_exit -> active=0.
- In SHOW, pulse key_recall (auto_on=1) with DWELL_MS=3 and tick_1khz every 10 clocks -> index advances after the 3rd tick, wraps 2->0. A second key_recall -> auto_on=0 and the index freezes.
- key_next and key_exit in the same cycle during WAIT -> IDLE next cycle, disp_valid=0, no further ram_addr change. key_next and key_prev together in SHOW -> no change.
- Assert rst low during WAIT -> all outputs at reset values asynchronously. Release rst and recall -> normal first fetch of index 0.
